// File: rtl/fifo_pkg.sv
// Shared definitions for the byte-fifo drain path: byte width and drain FSM states.
package fifo_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } drain_state_t;

endpackage

// File: rtl/fifo_word_drain_if.sv
// Bundle of the fifo read side and the packed-word valid/ready port of the drain.
interface fifo_word_drain_if #(
  parameter int ADDR_BITS = 5,
  parameter int BYTES     = 4
);
  import fifo_pkg::*;

  logic                      fifo_empty;
  logic [ADDR_BITS:0]        fifo_count;
  logic [BYTE_W-1:0]         fifo_rdata;
  logic                      fifo_ren;
  logic                      flush;
  logic                      m_valid;
  logic                      m_ready;
  logic [BYTE_W*BYTES-1:0]   m_data;
  logic [BYTES-1:0]          m_keep;

  // The drain block itself.
  modport master (
    input  fifo_empty, fifo_count, fifo_rdata, flush, m_ready,
    output fifo_ren, m_valid, m_data, m_keep
  );

  // The fifo plus the word sink around the drain.
  modport slave (
    output fifo_empty, fifo_count, fifo_rdata, flush, m_ready,
    input  fifo_ren, m_valid, m_data, m_keep
  );

endinterface

// File: rtl/fifo_drain_timer.sv
// Idle counter for a partially filled word; expires on the TIMEOUT-th idle cycle.
module fifo_drain_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] count_q, count_d;

  // Saturate at TIMEOUT so a stalled count can never wrap back to a fresh window.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != IDLE_W'(TIMEOUT))) begin
      count_d = count_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = inc_i && (count_q == IDLE_W'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_word_drain.sv
// Pops bytes from an async-read fifo and packs them little-endian into BYTES-wide words,
// emitting full words, or partial words with a keep mask on idle timeout or flush.
module fifo_word_drain
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS = 5,
  parameter int BYTES     = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic               clk,
  input  logic               rst,
  fifo_word_drain_if.master  bus
);

  localparam int FILL_W = $clog2(BYTES + 1);
  localparam int WORD_W = BYTE_W * BYTES;
  localparam int unsigned FIFO_DEPTH = 1 << ADDR_BITS;

  drain_state_t       state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [BYTES-1:0]   keep_q, keep_d;
  logic [BYTES-1:0]   lane_wr;
  logic               pop;
  logic               handshake;
  logic               last_byte;
  logic               flush_take;
  logic               idle_inc;
  logic               idle_clr;
  logic               idle_expire;

  assign pop        = bus.fifo_ren;
  assign handshake  = (state_q == HOLD) && bus.m_ready;
  assign last_byte  = pop && (fill_q == FILL_W'(BYTES - 1));
  // A flush arriving with the first byte still counts: that byte makes the word non-empty.
  assign flush_take = (state_q == FILL) && bus.flush && ((fill_q != '0) || pop);
  assign idle_inc   = (state_q == FILL) && (fill_q != '0) && bus.fifo_empty;
  assign idle_clr   = (state_q != FILL) || (fill_q == '0) || pop;

  fifo_drain_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (idle_clr),
    .inc_i    (idle_inc),
    .expire_o (idle_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last_byte || flush_take || idle_expire) state_d = HOLD;
      HOLD:    if (bus.m_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    bus.fifo_ren = 1'b0;
    bus.m_valid  = 1'b0;
    case (state_q)
      FILL:    bus.fifo_ren = !bus.fifo_empty && !rst;
      HOLD:    bus.m_valid  = 1'b1;
      default: ;
    endcase
  end

  assign fill_d = handshake ? '0 : (pop ? fill_q + FILL_W'(1) : fill_q);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign lane_wr[gi] = pop && (fill_q == FILL_W'(gi));
      assign data_d[gi*BYTE_W +: BYTE_W] = handshake   ? '0 :
                                           lane_wr[gi] ? bus.fifo_rdata :
                                                         data_q[gi*BYTE_W +: BYTE_W];
      assign keep_d[gi] = !handshake && (keep_q[gi] || lane_wr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      data_q <= '0;
      keep_q <= '0;
    end else begin
      fill_q <= fill_d;
      data_q <= data_d;
      keep_q <= keep_d;
    end
  end

  assign bus.m_data = data_q;
  assign bus.m_keep = keep_q;

  a_no_read_empty: assert property (@(posedge clk) disable iff (rst)
    !(bus.fifo_ren && bus.fifo_empty));
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.m_valid && !bus.m_ready) |=>
      (bus.m_valid && $stable(bus.m_data) && $stable(bus.m_keep)));
  a_keep_shape: assert property (@(posedge clk) disable iff (rst)
    bus.m_valid |-> ((bus.m_keep != '0) &&
                     ((bus.m_keep & (bus.m_keep + BYTES'(1))) == '0)));
  // Occupancy is only observed: it must agree with the empty flag and fit the fifo.
  a_count_sane: assert property (@(posedge clk) disable iff (rst)
    (bus.fifo_empty == (bus.fifo_count == '0)) && (32'(bus.fifo_count) <= FIFO_DEPTH));
  c_full_word: cover property (@(posedge clk) disable iff (rst)
    bus.m_valid && bus.m_ready && (&bus.m_keep));
  c_partial_word: cover property (@(posedge clk) disable iff (rst)
    bus.m_valid && bus.m_ready && !(&bus.m_keep));

endmodule

// File: tb/tb_fifo_word_drain.sv
// Directed bench: byte fifo model feeds the drain, a scoreboard checks every accepted word.
module tb_fifo_word_drain;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [7:0]  mem [0:63];
  int unsigned wr;
  int unsigned rd;
  beat_t       exp_q [$];
  int          tests;
  int          fails;

  fifo_word_drain_if #(.ADDR_BITS(5), .BYTES(4)) ifc ();

  fifo_word_drain #(
    .ADDR_BITS (5),
    .BYTES     (4),
    .TIMEOUT   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async-read fifo model: head byte visible combinationally, popped on the clock edge.
  assign ifc.fifo_empty = (wr == rd);
  assign ifc.fifo_count = 6'(wr - rd);
  assign ifc.fifo_rdata = mem[rd[5:0]];

  always @(posedge clk) begin
    if (ifc.fifo_ren) rd <= rd + 1;
  end

  always @(negedge clk) begin
    beat_t e;
    if (ifc.fifo_ren && ifc.fifo_empty) begin
      fails++;
      $display("FAIL ren_while_empty: ren=%0b empty=%0b, required ren=0", ifc.fifo_ren, ifc.fifo_empty);
    end
    if (!rst && ifc.m_valid && ifc.m_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: data=%h keep=%h, required no beat", ifc.m_data, ifc.m_keep);
      end else begin
        e = exp_q.pop_front();
        if (ifc.m_data !== e.data || ifc.m_keep !== e.keep) begin
          fails++;
          $display("FAIL beat: data=%h keep=%h, required data=%h keep=%h",
                   ifc.m_data, ifc.m_keep, e.data, e.keep);
        end else begin
          $display("[TB] beat data=%h keep=%h ok", ifc.m_data, ifc.m_keep);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr[5:0]] = b;
    wr = wr + 1;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k);
    beat_t e;
    e.data = d;
    e.keep = k;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("[TB] %s = %h ok", name, act);
    end
  endtask

  task automatic wait_sb(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    int n;
    int bad_valid;
    int bad_ren;
    int bad_data;
    int cnt_ren;
    int cnt_valid;
    tests = 0;
    fails = 0;
    wr = 0;
    rst = 1'b1;
    ifc.flush = 1'b0;
    ifc.m_ready = 1'b0;
    tick();
    tick();
    chk("rst_m_valid", 32'(ifc.m_valid), 32'd0);
    chk("rst_m_keep", 32'(ifc.m_keep), 32'd0);
    chk("rst_m_data", ifc.m_data, 32'd0);
    chk("rst_fifo_ren", 32'(ifc.fifo_ren), 32'd0);
    rst = 1'b0;
    tick();

    // 1) full word
    ifc.m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_beat(32'h44332211, 4'hF);
    wait_sb("t1", 20);

    // 2) partial word on idle timeout, valid exactly 8 cycles after last pop
    ifc.m_ready = 1'b0;
    push(8'hAA); push(8'hBB);
    expect_beat(32'h0000BBAA, 4'h3);
    for (int i = 0; i < 9; i++) tick();
    chk("t2_valid_before_timeout", 32'(ifc.m_valid), 32'd0);
    tick();
    chk("t2_valid_at_timeout", 32'(ifc.m_valid), 32'd1);
    ifc.m_ready = 1'b1;
    wait_sb("t2", 10);

    // 3) flush with the pop of the only byte, then flush on an empty word
    push(8'h01);
    ifc.flush = 1'b1;
    expect_beat(32'h00000001, 4'h1);
    tick();
    ifc.flush = 1'b0;
    chk("t3_valid_after_flush", 32'(ifc.m_valid), 32'd1);
    wait_sb("t3", 10);
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    cnt_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifc.m_valid) cnt_valid++;
      tick();
    end
    chk("t3_empty_flush_no_beat", 32'(cnt_valid), 32'd0);

    // 4) backpressure: held word stays put, no pops, then two beats in order
    ifc.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    expect_beat(32'h13121110, 4'hF);
    expect_beat(32'h17161514, 4'hF);
    n = 0;
    while (!ifc.m_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t4_valid_seen", 32'(ifc.m_valid), 32'd1);
    bad_valid = 0;
    bad_ren = 0;
    bad_data = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!ifc.m_valid) bad_valid++;
      if (ifc.fifo_ren) bad_ren++;
      if (ifc.m_data !== 32'h13121110 || ifc.m_keep !== 4'hF) bad_data++;
    end
    chk("t4_valid_held", 32'(bad_valid), 32'd0);
    chk("t4_ren_low", 32'(bad_ren), 32'd0);
    chk("t4_data_stable", 32'(bad_data), 32'd0);
    chk("t4_fifo_count", 32'(ifc.fifo_count), 32'd4);
    ifc.m_ready = 1'b1;
    wait_sb("t4", 30);

    // 5) empty fifo: nothing happens
    cnt_ren = 0;
    cnt_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.fifo_ren) cnt_ren++;
      if (ifc.m_valid) cnt_valid++;
      tick();
    end
    chk("t5_ren_count", 32'(cnt_ren), 32'd0);
    chk("t5_valid_count", 32'(cnt_valid), 32'd0);

    // 6) reset mid-word discards the partial word
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(); tick(); tick();
    chk("t6_keep_before_rst", 32'(ifc.m_keep), 32'h7);
    #2;
    rst = 1'b1;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    expect_beat(32'hB4B3B2B1, 4'hF);
    #1;
    chk("t6_rst_m_data", ifc.m_data, 32'd0);
    chk("t6_rst_m_keep", 32'(ifc.m_keep), 32'd0);
    chk("t6_rst_m_valid", 32'(ifc.m_valid), 32'd0);
    chk("t6_rst_ren", 32'(ifc.fifo_ren), 32'd0);
    #1;
    rst = 1'b0;
    wait_sb("t6", 20);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
